// File: rtl/spi_dac_pkg.sv
// Shared types and defaults for the SPI DAC sequencer and its serial-clock divider.
`timescale 1ns/1ps
package spi_dac_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: idle low while disabled, first edge after enable is rising, CLK_DIV cycles later.
`timescale 1ns/1ps
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tick;

    // Strobes flag the cycle whose closing edge flips sclk, so the sequencer
    // updates mosi on that very edge rather than one cycle later.
    assign w_tick   = en && (r_cnt == CW'(CLK_DIV - 1));
    assign rise_stb = w_tick && !r_sclk;
    assign fall_stb = w_tick &&  r_sclk;
    assign sclk     = r_sclk;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dac_sequencer.sv
// One SPI mode-0 write per accepted sample word: owns cs_n, frame timing and the SCLK gate.
`timescale 1ns/1ps
module spi_dac_sequencer
    import spi_dac_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP) + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_dac_sequencer: CLK_DIV must be at least 1");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || GAP < 1 || DATA_W < 2) begin : g_bad_timing
        $error("spi_dac_sequencer: CS_SETUP/CS_HOLD/GAP must be >= 1 and DATA_W >= 2");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bits;
    logic [DATA_W-1:0]  r_shift;
    logic               r_cs_n;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               w_abort_exit;
    logic               w_enter;
    logic               w_sclk_en;
    logic               w_rise;
    logic               w_fall;

    // Abort gates the divider in the same cycle so sclk is low on the edge that leaves SHIFT.
    assign w_sclk_en = (r_state == ST_SHIFT) && !abort;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (w_sclk_en),
        .sclk     (sclk),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_abort_exit = 1'b0;
        case (r_state)
            ST_IDLE:  if (s_valid && r_ready) w_state_nxt = ST_SETUP;
            ST_SETUP: begin
                if (abort) begin
                    w_state_nxt  = ST_GAP;
                    w_abort_exit = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt  = ST_GAP;
                    w_abort_exit = 1'b1;
                end else if (w_fall && r_bits == '0) begin
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt  = ST_GAP;
                    w_abort_exit = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = ST_GAP;
                end
            end
            ST_GAP:   if (r_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter = (w_state_nxt != r_state);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_cs_n    <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_cs_n  <= !(w_state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
            r_done  <= (r_state == ST_GAP) && (w_state_nxt == ST_IDLE) && !r_aborted;

            if (w_enter && w_state_nxt == ST_GAP)
                r_aborted <= w_abort_exit;

            // Counters load duration-1 on state entry and count down to zero.
            if (w_enter) begin
                case (w_state_nxt)
                    ST_SETUP: r_cnt <= CNT_W'(CS_SETUP - 1);
                    ST_HOLD:  r_cnt <= CNT_W'(CS_HOLD - 1);
                    ST_GAP:   r_cnt <= CNT_W'(GAP - 1);
                    default:  r_cnt <= '0;
                endcase
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_enter && w_state_nxt == ST_SHIFT)
                r_bits <= BIT_W'(DATA_W);
            else if (w_rise)
                r_bits <= r_bits - 1'b1;

            // The final fall (no bits left) does not shift, so mosi holds the LSB through HOLD.
            if (r_state == ST_IDLE && w_state_nxt == ST_SETUP)
                r_shift <= s_data;
            else if (w_enter && w_state_nxt == ST_GAP)
                r_shift <= '0;
            else if (w_fall && r_bits != '0)
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign s_ready = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cs_n    = r_cs_n;
    assign mosi    = r_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_dac_sequencer.sv
// Bench for spi_dac_sequencer: pin-level frame monitors checked against frame rules computed from the parameters.
`timescale 1ns/1ps
module tb_spi_dac_sequencer;

    localparam int DW       = 16;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int GAP      = 4;
    localparam int LOW2     = CS_SETUP + 2 * DW * 2 + CS_HOLD;
    localparam int LAT2     = LOW2 + GAP;
    localparam int LOW1     = CS_SETUP + 2 * DW * 1 + CS_HOLD;
    localparam int LAT1     = LOW1 + GAP;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          abort = 1'b0;
    logic          s_ready, busy, done, sclk, mosi, cs_n;

    logic          v1 = 1'b0;
    logic [DW-1:0] d1 = '0;
    logic          ab1 = 1'b0;
    logic          rdy1, busy1, done1, sclk1, mosi1, cs1;

    always #10 clk = ~clk;

    spi_dac_sequencer #(.DATA_W(DW), .CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) u_dut (
        .clk_in(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .abort(abort), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .cs_n(cs_n));

    spi_dac_sequencer #(.DATA_W(DW), .CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) u_dut1 (
        .clk_in(clk), .reset(reset), .s_valid(v1), .s_data(d1), .s_ready(rdy1),
        .abort(ab1), .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs1));

    typedef struct packed {
        logic [DW-1:0] bits;
        int            rises;
        int            low;
        int            gap;
    } frame_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor for the CLK_DIV=2 instance: one record per cs_n-low window.
    frame_t        frames[$];
    int            xfer_edges[$];
    logic [DW-1:0] xfer_words[$];
    int            done_edges[$];
    logic [DW-1:0] m_bits = '0;
    int            m_rises = 0, m_low = 0, m_high_run = 0, m_last_gap = 0;
    int            ready_hi = 0, m_bad_sclk = 0;
    logic          m_prev_cs = 1'b1, m_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (s_valid && s_ready && !reset) begin
            xfer_edges.push_back(cyc + 1);
            xfer_words.push_back(s_data);
        end
        if (s_ready) ready_hi <= ready_hi + 1;
        if (done) done_edges.push_back(cyc);
        if (cs_n && sclk) m_bad_sclk <= m_bad_sclk + 1;
        if (!cs_n) begin
            if (m_prev_cs) begin
                m_rises    <= 0;
                m_low      <= 1;
                m_bits     <= '0;
                m_last_gap <= m_high_run;
            end else begin
                m_low <= m_low + 1;
                if (sclk && !m_prev_sclk) begin
                    m_bits  <= {m_bits[DW-2:0], mosi};
                    m_rises <= m_rises + 1;
                end
            end
            m_high_run <= 0;
        end else begin
            if (!m_prev_cs) frames.push_back('{m_bits, m_rises, m_low, m_last_gap});
            m_high_run <= m_high_run + 1;
        end
        m_prev_cs   <= cs_n;
        m_prev_sclk <= sclk;
    end

    // Pin monitor for the CLK_DIV=1 instance.
    int   m1_low = 0, m1_rises = 0, m1_bad_mosi = 0, m1_bad_per = 0, m1_last_rise = -1;
    int   m1_frames = 0, m1_last_low = 0, m1_last_rises = 0, m1_done_edge = -1;
    logic m1_prev_cs = 1'b1, m1_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (done1) m1_done_edge <= cyc;
        if (!cs1) begin
            if (m1_prev_cs) begin
                m1_low       <= 1;
                m1_rises     <= 0;
                m1_last_rise <= -1;
            end else begin
                m1_low <= m1_low + 1;
                if (sclk1 && !m1_prev_sclk) begin
                    m1_rises     <= m1_rises + 1;
                    m1_last_rise <= cyc;
                    if (m1_last_rise >= 0 && cyc - m1_last_rise != 2) m1_bad_per <= m1_bad_per + 1;
                end
            end
            if (!mosi1) m1_bad_mosi <= m1_bad_mosi + 1;
        end else if (!m1_prev_cs) begin
            m1_last_low   <= m1_low;
            m1_last_rises <= m1_rises;
            m1_frames     <= m1_frames + 1;
        end
        m1_prev_cs   <= cs1;
        m1_prev_sclk <= sclk1;
    end

    task automatic do_xfer(input logic [DW-1:0] w, output bit ok);
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        for (int i = 0; i < 3000 && frames.size() < n; i++) @(negedge clk);
        ok = (frames.size() >= n);
        repeat (GAP + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s_ready, busy, done, sclk, mosi, cs_n} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_outs: got %b want 000001", {s_ready, busy, done, sclk, mosi, cs_n});
        end
        total++;
        if ({rdy1, busy1, done1, sclk1, mosi1, cs1} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_outs_div1: got %b want 000001", {rdy1, busy1, done1, sclk1, mosi1, cs1});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({s_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL idle_ready: got %b want 10", {s_ready, busy});
        end
    endtask

    task automatic test_single();
        bit ok;
        int n0 = frames.size(), d0 = done_edges.size(), x0 = xfer_edges.size();
        frame_t f;
        do_xfer(16'hA5C3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept: got timeout want accept"); end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({busy, s_ready, cs_n} !== 3'b100) begin
            bad++;
            $display("FAIL single_busy: got %b want 100", {busy, s_ready, cs_n});
        end
        wait_frames(n0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_frame: got timeout want frame"); end
        f = frames[n0];
        total++;
        if (f.rises !== DW) begin bad++; $display("FAIL single_rises: got %0d want %0d", f.rises, DW); end
        total++;
        if (f.bits !== 16'hA5C3) begin bad++; $display("FAIL single_bits: got %h want a5c3", f.bits); end
        total++;
        if (f.low !== LOW2) begin bad++; $display("FAIL single_cs_low: got %0d want %0d", f.low, LOW2); end
        total++;
        if (done_edges.size() - d0 !== 1) begin
            bad++;
            $display("FAIL single_done_cnt: got %0d want 1", done_edges.size() - d0);
        end
        total++;
        if (done_edges[d0] - xfer_edges[x0] !== LAT2) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d", done_edges[d0] - xfer_edges[x0], LAT2);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] w[3];
        int n0 = frames.size(), d0 = done_edges.size(), x0 = xfer_edges.size(), r0;
        bit got;
        for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
        r0 = ready_hi;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = w[i];
            got = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (s_ready) begin got = 1'b1; break; end
            end
            @(posedge clk);
            #1;
            total++;
            if (!got) begin bad++; $display("FAIL b2b_accept%0d: got timeout want accept", i); end
        end
        s_valid = 1'b0;
        total++;
        if (ready_hi - r0 !== 3) begin
            bad++;
            $display("FAIL b2b_ready_cycles: got %0d want 3", ready_hi - r0);
        end
        wait_frames(n0 + 3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_frames: got timeout want 3 frames"); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (xfer_words[x0 + i] !== w[i]) begin
                bad++;
                $display("FAIL b2b_word%0d: got %h want %h", i, xfer_words[x0 + i], w[i]);
            end
            total++;
            if (frames[n0 + i].bits !== w[i] || frames[n0 + i].low !== LOW2) begin
                bad++;
                $display("FAIL b2b_frame%0d: got %h/%0d want %h/%0d", i, frames[n0 + i].bits,
                         frames[n0 + i].low, w[i], LOW2);
            end
            if (i > 0) begin
                total++;
                if (frames[n0 + i].gap < GAP) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got %0d want >=%0d", i, frames[n0 + i].gap, GAP);
                end
                total++;
                if (xfer_edges[x0 + i] - xfer_edges[x0 + i - 1] !== LAT2 + 1) begin
                    bad++;
                    $display("FAIL b2b_period%0d: got %0d want %0d", i,
                             xfer_edges[x0 + i] - xfer_edges[x0 + i - 1], LAT2 + 1);
                end
            end
        end
        total++;
        if (done_edges.size() - d0 !== 3) begin
            bad++;
            $display("FAIL b2b_done_cnt: got %0d want 3", done_edges.size() - d0);
        end
    endtask

    task automatic test_abort();
        bit ok, got;
        logic [DW-1:0] w1 = DW'($urandom), w2 = DW'($urandom);
        int n0 = frames.size(), d0 = done_edges.size(), x0 = xfer_edges.size(), a_edge;
        do_xfer(w1, ok);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!cs_n && m_rises == 5) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL abort_rise5: got timeout want 5th rise"); end
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = w2;
        @(posedge clk);
        #1;
        a_edge = cyc;
        abort  = 1'b0;
        total++;
        if ({cs_n, sclk} !== 2'b10) begin
            bad++;
            $display("FAIL abort_pins: got %b want 10", {cs_n, sclk});
        end
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xfer_edges.size() > x0 + 1) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        total++;
        if (!got || xfer_edges[x0 + 1] - a_edge !== GAP + 1) begin
            bad++;
            $display("FAIL abort_next_accept: got %0d want %0d", xfer_edges[x0 + 1] - a_edge, GAP + 1);
        end
        wait_frames(n0 + 2, ok);
        total++;
        if (frames[n0].rises !== 5 || frames[n0].bits !== (w1 >> (DW - 5))) begin
            bad++;
            $display("FAIL abort_partial: got %0d/%h want 5/%h", frames[n0].rises, frames[n0].bits, w1 >> (DW - 5));
        end
        total++;
        if (frames[n0 + 1].bits !== w2 || frames[n0 + 1].low !== LOW2) begin
            bad++;
            $display("FAIL abort_after: got %h/%0d want %h/%0d", frames[n0 + 1].bits, frames[n0 + 1].low, w2, LOW2);
        end
        total++;
        if (done_edges.size() - d0 !== 1 || done_edges[d0] - xfer_edges[x0 + 1] !== LAT2) begin
            bad++;
            $display("FAIL abort_done: got cnt %0d want 1 (done only for second word)", done_edges.size() - d0);
        end
    endtask

    task automatic test_async_reset();
        bit ok, got;
        int n0;
        do_xfer(DW'($urandom), ok);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!cs_n && m_rises == 3) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL rst_rise3: got timeout want 3rd rise"); end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({cs_n, sclk, busy} !== 3'b100) begin
            bad++;
            $display("FAIL rst_async: got %b want 100", {cs_n, sclk, busy});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n0 = frames.size();
        do_xfer(16'h0001, ok);
        wait_frames(n0 + 1, ok);
        total++;
        if (!ok || frames[n0].bits !== 16'h0001 || frames[n0].rises !== DW || frames[n0].low !== LOW2) begin
            bad++;
            $display("FAIL rst_after_frame: got %h/%0d/%0d want 0001/%0d/%0d", frames[n0].bits,
                     frames[n0].rises, frames[n0].low, DW, LOW2);
        end
    endtask

    task automatic test_valid_toggle();
        bit ok;
        logic [DW-1:0] w = DW'($urandom);
        int n0 = frames.size(), d0 = done_edges.size(), x0 = xfer_edges.size();
        do_xfer(w, ok);
        for (int i = 0; i < 50; i++) begin
            s_valid = ~s_valid;
            s_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        wait_frames(n0 + 1, ok);
        total++;
        if (xfer_edges.size() - x0 !== 1) begin
            bad++;
            $display("FAIL toggle_xfers: got %0d want 1", xfer_edges.size() - x0);
        end
        total++;
        if (frames[n0].bits !== w || frames[n0].rises !== DW) begin
            bad++;
            $display("FAIL toggle_bits: got %h want %h", frames[n0].bits, w);
        end
        total++;
        if (done_edges.size() - d0 !== 1) begin
            bad++;
            $display("FAIL toggle_done: got %0d want 1", done_edges.size() - d0);
        end
    endtask

    task automatic test_clkdiv1();
        bit got = 1'b0;
        int t1 = 0;
        v1 = 1'b1;
        d1 = 16'hFFFF;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy1) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        t1 = cyc;
        v1 = 1'b0;
        for (int i = 0; i < 300 && m1_done_edge < t1; i++) @(negedge clk);
        #1;
        total++;
        if (!got || m1_frames !== 1) begin
            bad++;
            $display("FAIL div1_frame: got %0d frames want 1", m1_frames);
        end
        total++;
        if (m1_last_low !== LOW1 || m1_last_rises !== DW) begin
            bad++;
            $display("FAIL div1_cs_low: got %0d/%0d want %0d/%0d", m1_last_low, m1_last_rises, LOW1, DW);
        end
        total++;
        if (m1_bad_per !== 0 || m1_bad_mosi !== 0) begin
            bad++;
            $display("FAIL div1_period_mosi: got %0d/%0d want 0/0", m1_bad_per, m1_bad_mosi);
        end
        total++;
        if (m1_done_edge - t1 !== LAT1) begin
            bad++;
            $display("FAIL div1_latency: got %0d want %0d", m1_done_edge - t1, LAT1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_valid_toggle();
        test_clkdiv1();
        total++;
        if (m_bad_sclk !== 0) begin
            bad++;
            $display("FAIL sclk_idle_low: got %0d cycles with sclk high and cs_n high want 0", m_bad_sclk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
